// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_code_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 pins and debounces ps2_clk with a run-length filter;
// emits the filtered level plus a one-cycle pulse on its falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_pipe;
    logic [CW-1:0] run_cnt;

    // Synchronizers reset to 1 (bus idle) so reset release never fakes an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_pipe <= 2'b11;
            clk_filt  <= 1'b1;
            run_cnt   <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_pipe <= {data_pipe[0], ps2_data};
            fall      <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                run_cnt  <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign data_sync = data_pipe[1];

endmodule

// File: rtl/ps2_scan_code_receiver.sv
// PS/2 keyboard receiver: frame FSM, inter-edge timeout and F0/E0 prefix stripping.
// Define PS2_PARITY_CHECK_EN to drop frames that fail the odd-parity check.
module ps2_scan_code_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error
);

    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [TW-1:0] tmo_cnt;
    logic          brk_pend, ext_pend;
    ps2_code_t     code_q;
    logic          byte_done, err_n, par_ok;
    logic          clk_filt, fall, data_s, edge_s, tmo_hit;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_bit, par_bit_n;
`endif

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_filt),
        .fall      (fall),
        .data_sync (data_s)
    );

    // fall is registered together with the new low level, so both agree.
    assign edge_s  = fall & ~clk_filt;
    // A filtered edge in the same cycle wins over the timeout.
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES)) && !edge_s;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        byte_done = 1'b0;
        err_n     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bit_n = par_bit;
        par_ok    = ^{shreg, par_bit};
`else
        par_ok    = 1'b1;
`endif
        if (tmo_hit) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end else if (edge_s) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) state_n = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bit_n = data_s;
`endif
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s && par_ok) byte_done = 1'b1;
                    else                  err_n     = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tmo_cnt <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= par_bit_n;
`endif
            if (state == IDLE || edge_s)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Prefix decode and registered outputs; pending flags survive frame errors.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q      <= '0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= err_n;
            if (byte_done) begin
                if (shreg == PS2_BREAK_CODE) begin
                    brk_pend <= 1'b1;
                end else if (shreg == PS2_EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else begin
                    code_q     <= '{code: shreg, brk: brk_pend, ext: ext_pend};
                    code_valid <= 1'b1;
                    brk_pend   <= 1'b0;
                    ext_pend   <= 1'b0;
                end
            end
        end
    end

    assign scan_code   = code_q.code;
    assign is_break    = code_q.brk;
    assign is_extended = code_q.ext;

endmodule

// File: doc/ps2_scan_code_receiver.md
# ps2_scan_code_receiver

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and recovers 8-bit scan codes. It strips the `F0` (break) and `E0` (extended) prefixes and presents one registered code per keystroke event with a single-cycle valid strobe. It sits directly upstream of the scan-code-to-seven-segment decoder: `scan_code` feeds that decoder's `scan_code` input and holds its value between events.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized samples of `ps2_clk` required before the filtered clock changes state.
- `TIMEOUT_CYCLES`, default 10000: maximum system-clock cycles between filtered falling edges inside a frame before the frame is abandoned.
- `clock` input, 1 bit: system clock. All logic runs on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `ps2_clk` input, 1 bit: raw PS/2 clock pin, asynchronous to `clock`.
- `ps2_data` input, 1 bit: raw PS/2 data pin, asynchronous to `clock`.
- `scan_code` output, 8 bits: last emitted code, held between events.
- `code_valid` output, 1 bit: one-cycle pulse when `scan_code`, `is_break` and `is_extended` update.
- `is_break` output, 1 bit: the emitted code was preceded by `F0`.
- `is_extended` output, 1 bit: the emitted code was preceded by `E0`.
- `frame_error` output, 1 bit: one-cycle pulse when a frame is discarded because of a stop-bit error, a timeout or a parity error.

## Operation
- **Input synchronization:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
- **Clock filter:** the synchronized clock feeds a run-length filter. The filtered clock toggles only after `FILTER_LEN` consecutive samples that differ from its current value.
- **Sampling:** a falling edge of the filtered clock samples the synchronized data into the frame FSM.
- **Frame FSM, states `IDLE`, `DATA`, `PARITY`, `STOP`:**
  - `IDLE`: on an edge with data=0 (start bit), go to `DATA` and clear the bit counter. An edge with data=1 stays in `IDLE`.
  - `DATA`: shift bits in LSB first. After the 8th bit, go to `PARITY`.
  - `PARITY`: capture the parity bit and go to `STOP`.
  - `STOP`: data=1 completes the frame. Data=0 pulses `frame_error`. Both go to `IDLE`.
- **Timeout:** in any state other than `IDLE`, an inter-edge counter that reaches `TIMEOUT_CYCLES` pulses `frame_error` and forces `IDLE`. The counter clears on every filtered falling edge.
- **Prefix decode of a completed byte:**
  - `F0`: set `break_pending`, no strobe.
  - `E0`: set `ext_pending`, no strobe.
  - Any other value: load `scan_code` with the byte, `is_break` with `break_pending` and `is_extended` with `ext_pending`. Pulse `code_valid`. Clear both pending flags.
- **Pending flags:** a frame error does not clear pending flags. Only an emitted code or reset clears them.
- **Width rules:** the bit counter is 4 bits. The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.

## Timing
- **Reset values:**
  - `scan_code` = 8'h00.
  - `code_valid`, `is_break`, `is_extended` and `frame_error` = 0.
  - Filtered clock = 1.
  - FSM = `IDLE`, both pending flags = 0.
- **Latency:** `code_valid` rises 3 + `FILTER_LEN` `clock` cycles after the `ps2_clk` pin falls for the stop bit (2 synchronizer cycles + `FILTER_LEN` filter cycles + 1 output register cycle).
- **Pulse width:** `code_valid` and `frame_error` are exactly one cycle wide and are never asserted together.
- **Glitch rejection:** a `ps2_clk` pulse shorter than `FILTER_LEN` cycles produces no edge.
- **Reset mid-frame:** asserting `reset_n` low during a frame drops the partial frame and the pending flags immediately. No strobe is produced for that frame.
- **Simultaneous events:** a timeout and a filtered edge in the same cycle resolve as the edge. The counter clears and no error is raised.

## Configuration
- Macro: `PS2_PARITY_CHECK_EN`.
- **Defined:** in `STOP`, the frame completes only if the XOR of the 8 data bits and the parity bit is 1 (odd parity). A frame that fails the check pulses `frame_error`, the byte is dropped and the pending flags are unchanged.
- **Undefined:** the parity bit is captured and ignored. Only a stop-bit error or a timeout raises `frame_error`.

## Structure
- **Package `ps2_pkg`:**
  - `ps2_state_t` enum (`IDLE`, `DATA`, `PARITY`, `STOP`).
  - Constants `PS2_BREAK_CODE` = 8'hF0 and `PS2_EXT_CODE` = 8'hE0.
- **Sub-module `ps2_clk_filter`:** 2-flop synchronizer plus run-length filter. It outputs the filtered level and a one-cycle `fall` pulse.
- **Top level:** the frame FSM, the timeout counter and the prefix decoder live in `ps2_scan_code_receiver`.

## Test plan
- **Make code:** frame 8'h1C, parity 0, stop 1 -> one `code_valid` pulse, `scan_code`=8'h1C, `is_break`=0, `is_extended`=0.
- **Break sequence:** frames F0 then 1C -> exactly one `code_valid` pulse, `scan_code`=8'h1C, `is_break`=1. A following 8'h32 frame gives `is_break`=0.
- **Extended code:** frames E0 then 75 -> `scan_code`=8'h75, `is_extended`=1. Frames E0 F0 75 give both flags set.
- **Bad parity:** frame 8'h24 with a wrong parity bit, macro defined -> `frame_error` pulse, no `code_valid`, `scan_code` holds its previous value. With the macro undefined -> `code_valid` with 8'h24.
- **Timeout recovery:** 5 bits of a frame, then the clock idle for `TIMEOUT_CYCLES`+5 cycles -> `frame_error` pulse. A following clean frame 8'h32 decodes to 8'h32.
- **Glitch and reset:** a `FILTER_LEN`-2 cycle low glitch on `ps2_clk` in `IDLE` -> no state change. `reset_n` low after 4 bits of a frame -> all outputs 0 and a clean decode of the next frame.
